// File: rtl/pipe_io_pkg.sv
// Shared constants and address decode for the pipelined computer's I/O page.
package pipe_io_pkg;

    localparam logic [7:0] IN_BASE   = 8'h00;
    localparam logic [7:0] OUT_BASE  = 8'h40;
    localparam logic [7:0] FLAG_ADDR = 8'h80;
    localparam logic [7:0] MASK_ADDR = 8'h84;
    localparam int         MAX_CH    = 8;

    typedef enum logic [2:0] {
        REG_IN,
        REG_OUT,
        REG_FLAG,
        REG_MASK,
        REG_NONE
    } io_region_e;

    // Classify a byte offset into the register region it targets.
    function automatic io_region_e decode_region(input logic [7:0] addr);
        logic [7:0] word;
        word = {addr[7:2], 2'b00};
        if (word[7:6] == IN_BASE[7:6])       return REG_IN;
        else if (word[7:6] == OUT_BASE[7:6]) return REG_OUT;
        else if (word == FLAG_ADDR)          return REG_FLAG;
        else if (word == MASK_ADDR)          return REG_MASK;
        else                                 return REG_NONE;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// One input channel: two-flop synchroniser, debounce counter with candidate,
// accepted value, and a "changed" pulse asserted in the cycle before the edge
// on which the accepted value updates.
module io_debounce #(
    parameter int DW      = 8,
    parameter int DEB_CYC = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] raw,
    output logic [DW-1:0] value,
    output logic          changed
);

    localparam int            CW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

    logic [DW-1:0] sync1, sync2, cand, cand_next;
    logic [CW-1:0] cnt, cnt_next;

    // Next candidate/counter; accept once the counter arrives at its final count.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        cand_next = cand;
        cnt_next  = cnt;
        if (sync2 != cand) begin
            cand_next = sync2;
            cnt_next  = '0;
        end else if (cnt != LAST) begin
            cnt_next = cnt + 1'b1;
        end
        changed = (cnt_next == LAST) && (cand_next != value);
    end

    // Synchroniser, debounce state and accepted value.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
            value <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cand  <= cand_next;
            cnt   <= cnt_next;
            if (changed) value <= cand_next;
        end
    end

endmodule

// File: rtl/pipe_io_ports.sv
// Memory-mapped I/O controller for the MEM stage: NIN debounced inputs with
// sticky read-to-clear change flags, NOUT registered outputs.
// Optional feature: define IO_IRQ_EN to add the irq mask register at 0x84 and
// a registered level interrupt; otherwise irq is tied low.
module pipe_io_ports
    import pipe_io_pkg::*;
#(
    parameter int NIN     = 3,
    parameter int NOUT    = 3,
    parameter int DW      = 8,
    parameter int DEB_CYC = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_sel,
    input  logic [7:0]         io_addr,
    input  logic               io_we,
    input  logic               io_re,
    input  logic [31:0]        io_wdata,
    output logic [31:0]        io_rdata,
    input  logic [NIN*DW-1:0]  in_port,
    output logic [NOUT*DW-1:0] out_port,
    output logic               irq
);

    io_region_e       region;
    logic [3:0]       chan;
    logic             wr, rd_clr;
    logic [DW-1:0]    in_val  [NIN];
    logic [NIN-1:0]   in_chg;
    logic [NIN-1:0]   flag;
    logic [DW-1:0]    out_reg [NOUT];
    logic             unused_bits;

    assign region      = decode_region(io_addr);
    assign chan        = io_addr[5:2];
    assign wr          = io_sel & io_we;
    assign rd_clr      = io_sel & io_re & (region == REG_FLAG);
    assign unused_bits = ^{io_addr[1:0], io_wdata};

    for (genvar i = 0; i < NIN; i++) begin : g_in
        io_debounce #(.DW(DW), .DEB_CYC(DEB_CYC)) u_deb (
            .clock   (clock),
            .reset   (reset),
            .raw     (in_port[i*DW +: DW]),
            .value   (in_val[i]),
            .changed (in_chg[i])
        );
    end

    for (genvar i = 0; i < NOUT; i++) begin : g_out
        assign out_port[i*DW +: DW] = out_reg[i];
    end

    // Sticky change flags; a flag setting on the clearing edge survives.
    always_ff @(posedge clock) begin
        if (reset)       flag <= '0;
        else if (rd_clr) flag <= in_chg;
        else             flag <= flag | in_chg;
    end

    // Output registers, written by io_sel & io_we inside the output page.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NOUT; i++) out_reg[i] <= '0;
        end else if (wr && region == REG_OUT) begin
            for (int i = 0; i < NOUT; i++)
                if (chan == 4'(i)) out_reg[i] <= io_wdata[DW-1:0];
        end
    end

`ifdef IO_IRQ_EN
    logic [NIN-1:0] mask;
    logic           irq_q;

    // Mask register and registered interrupt level.
    always_ff @(posedge clock) begin
        if (reset) begin
            mask  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (wr && region == REG_MASK) mask <= io_wdata[NIN-1:0];
            irq_q <= |(flag & mask);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Read mux: combinational from the address and current register state.
    always_comb begin
        io_rdata = '0;
        case (region)
            REG_IN: begin
                for (int i = 0; i < NIN; i++)
                    if (chan == 4'(i)) io_rdata = 32'(in_val[i]);
            end
            REG_OUT: begin
                for (int i = 0; i < NOUT; i++)
                    if (chan == 4'(i)) io_rdata = 32'(out_reg[i]);
            end
            REG_FLAG: io_rdata = 32'(flag);
`ifdef IO_IRQ_EN
            REG_MASK: io_rdata = 32'(mask);
`endif
            default:  io_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pipe_io_ports.sv
// Directed self-checking bench for pipe_io_ports (default parameters).
module tb_pipe_io_ports;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_sel, io_we, io_re;
    logic [7:0]  io_addr;
    logic [31:0] io_wdata, io_rdata;
    logic [23:0] in_port, out_port;
    logic        irq;
    logic [31:0] d;

    int checks = 0;
    int errors = 0;

    pipe_io_ports dut (
        .clock    (clock),
        .reset    (reset),
        .io_sel   (io_sel),
        .io_addr  (io_addr),
        .io_we    (io_we),
        .io_re    (io_re),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .in_port  (in_port),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic peek(input logic [7:0] a, output logic [31:0] v);
        io_sel = 1'b0; io_we = 1'b0; io_re = 1'b0; io_addr = a;
        #1 v = io_rdata;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] v);
        io_sel = 1'b1; io_we = 1'b1; io_re = 1'b0; io_addr = a; io_wdata = v;
        @(negedge clock);
        io_sel = 1'b0; io_we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] v);
        io_sel = 1'b1; io_we = 1'b0; io_re = 1'b1; io_addr = a;
        #1 v = io_rdata;
        @(negedge clock);
        io_sel = 1'b0; io_re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; io_sel = 1'b0; io_we = 1'b0; io_re = 1'b0;
        io_addr = 8'h00; io_wdata = '0; in_port = 24'hFFFFFF;

        // Reset with inputs all ones.
        tick(2);
        check("rst_out_port", 32'(out_port), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        peek(8'h00, d); check("rst_in0", d, 32'h0);
        peek(8'h40, d); check("rst_out0", d, 32'h0);
        peek(8'h80, d); check("rst_flags", d, 32'h0);
        reset = 1'b0;

        // Accepted exactly 2 + 16 edges after release.
        tick(17);
        peek(8'h00, d); check("lat_17", d, 32'h0);
        tick(1);
        peek(8'h00, d); check("lat_18_in0", d, 32'hFF);
        peek(8'h08, d); check("lat_18_in2", d, 32'hFF);
        peek(8'h80, d); check("lat_flags", d, 32'h7);
        bus_read(8'h80, d); check("clr_read", d, 32'h7);
        peek(8'h80, d); check("clr_after", d, 32'h0);

        in_port = 24'h000000;
        tick(30);
        peek(8'h00, d); check("back_to_0", d, 32'h0);
        bus_read(8'h80, d); check("clr_read2", d, 32'h7);

        // Write / readback, out-of-range channels.
        bus_write(8'h44, 32'h1A5);
        check("wr_out1", 32'(out_port[15:8]), 32'hA5);
        bus_read(8'h44, d); check("rd_out1", d, 32'hA5);
        bus_write(8'h4C, 32'hFF);
        bus_read(8'h4C, d); check("rd_out3", d, 32'h0);
        check("out_port_keep", 32'(out_port), 32'h00A500);
        peek(8'h0C, d); check("rd_in3", d, 32'h0);
        peek(8'h88, d); check("rd_hole", d, 32'h0);

        // Glitch shorter than the debounce window.
        in_port[7:0] = 8'h3C;
        tick(10);
        in_port[7:0] = 8'h00;
        tick(30);
        peek(8'h00, d); check("glitch_val", d, 32'h0);
        peek(8'h80, d); check("glitch_flag", d, 32'h0);

        // Held change is accepted.
        in_port[7:0] = 8'h3C;
        tick(30);
        peek(8'h00, d); check("hold_val", d, 32'h3C);
        peek(8'h80, d); check("hold_flag", d, 32'h1);

        // Clearing read on the edge where channel 1 accepts.
        in_port[15:8] = 8'h55;
        tick(17);
        peek(8'h04, d); check("coll_pre_in1", d, 32'h0);
        bus_read(8'h80, d); check("coll_read", d, 32'h1);
        peek(8'h80, d); check("coll_after", d, 32'h2);
        peek(8'h04, d); check("coll_in1", d, 32'h55);

`ifdef IO_IRQ_EN
        bus_read(8'h80, d); check("irq_clr0", d, 32'h2);
        bus_write(8'h84, 32'h2);
        bus_read(8'h84, d); check("mask_rd", d, 32'h2);
        in_port[7:0] = 8'h11;
        tick(30);
        check("irq_masked", 32'(irq), 32'h0);
        peek(8'h80, d); check("irq_flag0", d, 32'h1);
        bus_read(8'h80, d); check("irq_clr1", d, 32'h1);
        in_port[15:8] = 8'h66;
        tick(18);
        peek(8'h80, d); check("irq_flag1", d, 32'h2);
        check("irq_lag", 32'(irq), 32'h0);
        tick(1);
        check("irq_set", 32'(irq), 32'h1);
        bus_read(8'h80, d); check("irq_clr2", d, 32'h2);
        check("irq_hold", 32'(irq), 32'h1);
        tick(1);
        check("irq_drop", 32'(irq), 32'h0);
`else
        bus_write(8'h84, 32'hFF);
        bus_read(8'h84, d); check("mask_absent", d, 32'h0);
        in_port[7:0] = 8'h11;
        tick(30);
        check("irq_tied", 32'(irq), 32'h0);
        bus_read(8'h80, d); check("flags_nomask", d, 32'h3);
`endif

        // Simultaneous write and read: read shows the old value.
        bus_write(8'h40, 32'h12);
        io_sel = 1'b1; io_we = 1'b1; io_re = 1'b1; io_addr = 8'h40; io_wdata = 32'h34;
        #1 check("rw_old", io_rdata, 32'h12);
        @(negedge clock);
        io_sel = 1'b0; io_we = 1'b0; io_re = 1'b0;
        check("rw_port", 32'(out_port[7:0]), 32'h34);
        bus_read(8'h40, d); check("rw_new", d, 32'h34);

        // Reset mid-debounce, with a concurrent write.
        in_port[23:16] = 8'h77;
        tick(5);
        reset = 1'b1; io_sel = 1'b1; io_we = 1'b1; io_addr = 8'h48; io_wdata = 32'h99;
        @(negedge clock);
        io_sel = 1'b0; io_we = 1'b0;
        check("rst2_out_port", 32'(out_port), 32'h0);
        peek(8'h48, d); check("rst2_out2", d, 32'h0);
        peek(8'h08, d); check("rst2_in2", d, 32'h0);
        peek(8'h80, d); check("rst2_flags", d, 32'h0);
        in_port[23:16] = 8'h00;
        reset = 1'b0;
        tick(30);
        peek(8'h08, d); check("rst2_discard", d, 32'h0);
        peek(8'h80, d); check("rst2_flag2", 32'(d[2]), 32'h0);
        peek(8'h00, d); check("rst2_in0", d, 32'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_io_ports.md
Name: pipe_io_ports

Overview:
- Parametrised memory-mapped I/O controller for the pipelined computer's MEM stage.
- Generalises the fixed three-in/three-out 8-bit switch and display ports to NIN input and NOUT output channels of width DW.
- Adds per-input synchronisation, debouncing, sticky change flags with read-to-clear, and an optional interrupt request.

Parameters:
- NIN, 3, number of input channels (1..8).
- NOUT, 3, number of output channels (1..8).
- DW, 8, channel data width (1..32).
- DEB_CYC, 16, cycles an input must be stable before it is accepted (>=1).

Ports:
- clock  in  1  system clock; everything samples on its rising edge.
- reset  in  1  synchronous, active-high reset.
- io_sel  in  1  access targets the I/O page (address decode done by the MEM stage).
- io_addr  in  8  byte offset within the I/O page; bits [1:0] ignored.
- io_we  in  1  write strobe, qualified by io_sel.
- io_re  in  1  read strobe, qualified by io_sel; drives read side effects only.
- io_wdata  in  32  write data.
- io_rdata  out  32  read data, combinational from io_addr and the current registers.
- in_port  in  NIN*DW  raw asynchronous inputs; channel i is [i*DW +: DW].
- out_port  out  NOUT*DW  registered outputs; channel i is [i*DW +: DW].
- irq  out  1  level interrupt request (IO_IRQ_EN only; otherwise 0).

Behaviour:
- Address map (word offsets):
  - 0x00+4i: debounced input i, zero-extended, read-only.
  - 0x40+4i: output register i, read/write; writes take io_wdata[DW-1:0].
  - 0x80: change-flag vector, bits [NIN-1:0], read-to-clear.
  - 0x84: irq mask, bits [NIN-1:0], read/write (IO_IRQ_EN only).
  - Any other offset, or a channel index past NIN/NOUT: reads 0, writes ignored.
- Input path per channel:
  - Two-flop synchroniser, then a debounce counter.
  - The counter reloads to 0 whenever the synchronised value differs from the candidate; the candidate then takes the new value.
  - When the counter reaches DEB_CYC-1 and the candidate differs from the accepted value: the accepted value updates and flag[i] sets in the same edge.
  - Latency from a raw input change to the accepted value: 2 + DEB_CYC cycles, with the input held steady throughout.
  - A glitch shorter than DEB_CYC cycles never changes the accepted value or the flag.
  - The counter saturates at DEB_CYC-1; it does not wrap.
- Writes: the output register updates on the clock edge where io_sel & io_we. out_port reflects the new value the following cycle.
- Read-to-clear: io_sel & io_re at 0x80 clears all flags that were set at that edge. A flag setting on the same edge wins and stays set.
- Simultaneous io_we and io_re: both take effect. io_rdata shows the pre-write value.
- Reset behaviour:
  - Synchronisers, candidates and accepted values: 0.
  - Counters: 0. Flags: 0. Mask: 0. Output registers: 0. irq: 0.
  - io_rdata follows its decode; with io_addr = 0 it reads 0.
  - Reset mid-debounce discards the pending candidate.
  - Reset dominates any concurrent write or read-clear.

Optional Feature:
- IO_IRQ_EN defined:
  - Mask register at 0x84 is present.
  - irq registered: irq <= |(flag & mask), so it follows a flag set by one cycle and deasserts the cycle after the clearing read.
- IO_IRQ_EN undefined:
  - No mask register; 0x84 reads 0 and writes are ignored.
  - irq tied to 0.

Decomposition:
- Package pipe_io_pkg holds the address-offset constants (IN_BASE=0x00, OUT_BASE=0x40, FLAG_ADDR=0x80, MASK_ADDR=0x84) and the max-channel limit of 8.
- Sub-module io_debounce (one instance per input channel): synchroniser, counter, candidate, accepted value, and a one-cycle "changed" pulse.

Test Plan:
- Reset: assert reset 2 cycles with in_port all-ones → out_port=0, all reads 0, irq=0; after release, input 0 reads 0xFF exactly 2+16 cycles later.
- Write/readback: write 0x1A5 to 0x44 → out_port[15:8]=0xA5 the next cycle; read 0x44 returns 0x000000A5. Write 0x4C (channel 3 with NOUT=3) → ignored, reads 0.
- Debounce: pulse in_port[7:0]=0x3C for 10 cycles, then back to 0 → accepted value stays 0, flag stays 0. Hold 0x3C for 30 cycles → reads 0x3C and flag bit0=1.
- Read-to-clear collision: read 0x80 on the same edge channel 1 accepts a change → that read returns the old flags, and bit1 remains set afterwards.
- IRQ (IO_IRQ_EN): mask=0x2; change channel 0 → irq stays 0. Change channel 1 → irq=1 one cycle after the flag; read 0x80 → irq=0 the next cycle.
- Simultaneous write and read at 0x40: io_rdata shows the old value, and the register holds the new value afterwards.
